// File: rtl/inv_shift_row_byte_sub_if.sv
// Block-protocol and memory-port bundle for the InvShiftRows/InvSubBytes stage.
// master is the stage itself; slave is the RAM/ROM/controller side.
interface inv_shift_row_byte_sub_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [AW-1:0]     statemt_address0;
  logic              statemt_ce0;
  logic              statemt_we0;
  logic [DATA_W-1:0] statemt_d0;
  logic [DATA_W-1:0] statemt_q0;
  logic [AW-1:0]     statemt_address1;
  logic              statemt_ce1;
  logic              statemt_we1;
  logic [DATA_W-1:0] statemt_d1;
  logic [DATA_W-1:0] statemt_q1;
  logic [7:0]        invSbox_address0;
  logic              invSbox_ce0;
  logic [7:0]        invSbox_q0;
  logic [7:0]        invSbox_address1;
  logic              invSbox_ce1;
  logic [7:0]        invSbox_q1;
  logic [4:0]        fsm_state;

  modport master (
    input  ap_start, statemt_q0, statemt_q1, invSbox_q0, invSbox_q1,
    output ap_done, ap_idle, ap_ready,
    output statemt_address0, statemt_ce0, statemt_we0, statemt_d0,
    output statemt_address1, statemt_ce1, statemt_we1, statemt_d1,
    output invSbox_address0, invSbox_ce0, invSbox_address1, invSbox_ce1,
    output fsm_state
  );

  modport slave (
    output ap_start, statemt_q0, statemt_q1, invSbox_q0, invSbox_q1,
    input  ap_done, ap_idle, ap_ready,
    input  statemt_address0, statemt_ce0, statemt_we0, statemt_d0,
    input  statemt_address1, statemt_ce1, statemt_we1, statemt_d1,
    input  invSbox_address0, invSbox_ce0, invSbox_address1, invSbox_ce1,
    input  fsm_state
  );
endinterface

// File: rtl/inv_shift_row_byte_sub.sv
// AES decrypt stage: InvShiftRows then InvSubBytes applied in place to the
// 16-byte state in the statemt RAM, using an external dual-port inverse S-box.
module inv_shift_row_byte_sub #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  inv_shift_row_byte_sub_if.master bus
);

  // Handshake: ap_start is a level request sampled only in IDLE and ignored
  // elsewhere; ap_done and ap_ready pulse together for exactly one cycle on the
  // final write; ap_idle is high in IDLE whenever ap_start is low.
  localparam logic [4:0] S_IDLE      = 5'b00001;
  localparam logic [4:0] S_LOAD      = 5'b00010;
  localparam logic [4:0] S_LOAD_LAST = 5'b00100;
  localparam logic [4:0] S_SUB       = 5'b01000;
  localparam logic [4:0] S_SUB_LAST  = 5'b10000;

  logic [4:0] state;
  logic [2:0] k;
  logic [2:0] kp;
  logic [7:0] sbuf [16];
  logic       wr;
  logic       unused_hi;

  // Byte feeding destination i after rotating row r right by r: {c-r, r}.
  function automatic logic [3:0] src_idx(input logic [3:0] i);
    logic [1:0] r;
    logic [1:0] c;
    r = i[1:0];
    c = i[3:2];
    return {c - r, r};
  endfunction

  // Data returned this cycle belongs to the pair addressed on the previous
  // cycle; k wraps to 0 on entering the *_LAST states, so kp is 7 there.
  assign kp = k - 3'd1;
  assign wr = ((state == S_SUB) && (k != 3'd0)) || (state == S_SUB_LAST);

  assign unused_hi = ^{bus.statemt_q0[DATA_W-1:8], bus.statemt_q1[DATA_W-1:8]};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
      k     <= 3'd0;
      for (int i = 0; i < 16; i++) sbuf[i] <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ap_start) begin
            k     <= 3'd0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (k != 3'd0) begin
            sbuf[{kp, 1'b0}] <= bus.statemt_q0[7:0];
            sbuf[{kp, 1'b1}] <= bus.statemt_q1[7:0];
          end
          k <= k + 3'd1;
          if (k == 3'd7) state <= S_LOAD_LAST;
        end
        S_LOAD_LAST: begin
          sbuf[14] <= bus.statemt_q0[7:0];
          sbuf[15] <= bus.statemt_q1[7:0];
          k        <= 3'd0;
          state    <= S_SUB;
        end
        S_SUB: begin
          k <= k + 3'd1;
          if (k == 3'd7) state <= S_SUB_LAST;
        end
        S_SUB_LAST: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.statemt_address0 = '0;
    bus.statemt_ce0      = 1'b0;
    bus.statemt_we0      = 1'b0;
    bus.statemt_d0       = '0;
    bus.statemt_address1 = '0;
    bus.statemt_ce1      = 1'b0;
    bus.statemt_we1      = 1'b0;
    bus.statemt_d1       = '0;
    bus.invSbox_address0 = 8'h00;
    bus.invSbox_ce0      = 1'b0;
    bus.invSbox_address1 = 8'h00;
    bus.invSbox_ce1      = 1'b0;
    if (state == S_LOAD) begin
      bus.statemt_ce0      = 1'b1;
      bus.statemt_ce1      = 1'b1;
      bus.statemt_address0 = AW'({k, 1'b0});
      bus.statemt_address1 = AW'({k, 1'b1});
    end
    if (state == S_SUB) begin
      bus.invSbox_ce0      = 1'b1;
      bus.invSbox_ce1      = 1'b1;
      bus.invSbox_address0 = sbuf[src_idx({k, 1'b0})];
      bus.invSbox_address1 = sbuf[src_idx({k, 1'b1})];
    end
    if (wr) begin
      bus.statemt_ce0      = 1'b1;
      bus.statemt_ce1      = 1'b1;
      bus.statemt_we0      = 1'b1;
      bus.statemt_we1      = 1'b1;
      bus.statemt_address0 = AW'({kp, 1'b0});
      bus.statemt_address1 = AW'({kp, 1'b1});
      bus.statemt_d0       = DATA_W'(bus.invSbox_q0);
      bus.statemt_d1       = DATA_W'(bus.invSbox_q1);
    end
  end

  assign bus.ap_done   = (state == S_SUB_LAST);
  assign bus.ap_ready  = (state == S_SUB_LAST);
  assign bus.ap_idle   = (state == S_IDLE) && !bus.ap_start;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_inv_shift_row_byte_sub.sv
// Bench for inv_shift_row_byte_sub: RAM/ROM models, cycle-level protocol model
// and a state-level reference of InvShiftRows+InvSubBytes.
module tb_inv_shift_row_byte_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_shift_row_byte_sub_if #(.DATA_W(32), .AW(5)) bus();

  inv_shift_row_byte_sub #(.DATA_W(32), .AW(5)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];

  logic [31:0] mem [32];
  logic [31:0] pre_mem [32];
  logic        pre_go = 1'b0;
  logic [7:0]  rom [256];
  logic [7:0]  sbox_ref [256];
  logic [7:0]  isbox_ref [256];
  bit          rom_real = 1'b0;
  logic [31:0] model_mem [16];
  int          phase = -1;
  int          done_cyc [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM / ROM models ----------------
  always @(posedge clk) begin
    if (pre_go) for (int i = 0; i < 32; i++) mem[i] = pre_mem[i];
    if (bus.statemt_ce0) begin
      if (bus.statemt_we0) mem[bus.statemt_address0] = bus.statemt_d0;
      else bus.statemt_q0 <= mem[bus.statemt_address0];
    end
    if (bus.statemt_ce1) begin
      if (bus.statemt_we1) mem[bus.statemt_address1] = bus.statemt_d1;
      else bus.statemt_q1 <= mem[bus.statemt_address1];
    end
    if (bus.invSbox_ce0) bus.invSbox_q0 <= rom[bus.invSbox_address0];
    if (bus.invSbox_ce1) bus.invSbox_q1 <= rom[bus.invSbox_address1];
  end

  // ---------------- GF(2^8) reference tables ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbox_ref[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox_ref[sbox_ref[x]] = 8'(x);
  endtask

  task automatic set_rom(input bit real_box);
    rom_real = real_box;
    for (int i = 0; i < 256; i++) rom[i] = real_box ? isbox_ref[i] : 8'(i);
  endtask

  // ---------------- protocol model ----------------
  // phase = cycle number within an operation (1..18), -1 when idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase = -1;
    else if (phase == -1) begin
      if (bus.ap_start) phase = 1;
    end else if (phase == 18) phase = -1;
    else phase = phase + 1;
  end

  always @(negedge clk) begin
    bit rd;
    bit wr;
    bit sb;
    rd = (phase >= 1) && (phase <= 8);
    wr = (phase >= 11) && (phase <= 18);
    sb = (phase >= 10) && (phase <= 17);
    check("ap_done", 32'(bus.ap_done), 32'(phase == 18));
    check("ap_ready", 32'(bus.ap_ready), 32'(phase == 18));
    check("ap_idle", 32'(bus.ap_idle), 32'((phase == -1) && !bus.ap_start));
    check("ram_ce", 32'({bus.statemt_ce0, bus.statemt_ce1}), (rd || wr) ? 32'd3 : 32'd0);
    check("ram_we", 32'({bus.statemt_we0, bus.statemt_we1}), wr ? 32'd3 : 32'd0);
    check("sbox_ce", 32'({bus.invSbox_ce0, bus.invSbox_ce1}), sb ? 32'd3 : 32'd0);
    check("fsm_onehot", 32'($onehot(bus.fsm_state)), 32'd1);
    if (rd) begin
      check("rd_addr0", 32'(bus.statemt_address0), 32'(2 * (phase - 1)));
      check("rd_addr1", 32'(bus.statemt_address1), 32'(2 * (phase - 1) + 1));
    end
    if (wr) begin
      check("wr_addr0", 32'(bus.statemt_address0), 32'(2 * (phase - 11)));
      check("wr_addr1", 32'(bus.statemt_address1), 32'(2 * (phase - 11) + 1));
      check("wr_d_hi", (bus.statemt_d0 | bus.statemt_d1) >> 8, 32'd0);
    end else begin
      check("d_quiet", bus.statemt_d0 | bus.statemt_d1, 32'd0);
    end
  end

  // ---------------- state-level reference ----------------
  function automatic logic [7:0] box(input logic [7:0] x);
    return rom_real ? isbox_ref[x] : x;
  endfunction

  task automatic snap_model();
    for (int i = 0; i < 16; i++) model_mem[i] = mem[i];
  endtask

  // One application; only the first n_written entries reach the RAM.
  task automatic apply_model(input int n_written);
    logic [31:0] res [16];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[r + 4 * c] = {24'h0, box(model_mem[r + 4 * ((c - r + 4) % 4)][7:0])};
    for (int i = 0; i < n_written; i++) model_mem[i] = res[i];
  endtask

  task automatic push_expected();
    for (int i = 0; i < 16; i++) exp_q.push_back(model_mem[i]);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_mem%0d", tag, i), mem[i], exp_q.pop_front());
    for (int i = 16; i < 32; i++)
      check($sformatf("%s_hi%0d", tag, i), mem[i], 32'hA5);
  endtask

  // ---------------- drivers ----------------
  // pattern: 0 ramp 16r+c, 1 all 0x63, 2 random with entry0=FFFFFF7C, 3 random
  task automatic load_mem(input int pattern);
    for (int i = 0; i < 32; i++) begin
      if (i >= 16) pre_mem[i] = 32'hA5;
      else if (pattern == 0) pre_mem[i] = 32'(16 * (i % 4) + i / 4);
      else if (pattern == 1) pre_mem[i] = 32'h63;
      else pre_mem[i] = $urandom;
    end
    if (pattern == 2) pre_mem[0] = 32'hFFFFFF7C;
    pre_go = 1'b1;
    @(posedge clk); #1;
    pre_go = 1'b0;
  endtask

  // mode: 0 one-cycle pulse, 1 random toggling, 2 held high
  task automatic run_ops(input int n_ops, input int mode, input int abort_at);
    int  seen = 0;
    bit  aborted = 1'b0;
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    @(posedge clk); #1;
    bus.ap_start = 1'b1;
    for (int n = 1; n <= 20 * n_ops + 5 && seen < n_ops && !aborted; n++) begin
      @(posedge clk); #1;
      if (mode == 0) bus.ap_start = 1'b0;
      else if (mode == 1) bus.ap_start = 1'($urandom_range(0, 1));
      if (n == abort_at) begin
        rst_n   = 1'b0;
        aborted = 1'b1;
      end
      @(negedge clk);
      if (bus.ap_done && seen < 2) begin
        done_cyc[seen] = n;
        seen++;
      end
    end
    @(posedge clk); #1;
    bus.ap_start = 1'b0;
    if (abort_at == 0) check("done_count", 32'(seen), 32'(n_ops));
  endtask

  task automatic normal_op(input string tag, input int pattern, input int mode);
    load_mem(pattern);
    snap_model();
    apply_model(16);
    push_expected();
    run_ops(1, mode, 0);
    check({tag, "_latency"}, 32'(done_cyc[0]), 32'd18);
    check_mem(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    bus.ap_start = 1'b0;
    build_tables();
    check("pin_sbox_00", 32'(sbox_ref[8'h00]), 32'h63);
    check("pin_sbox_53", 32'(sbox_ref[8'h53]), 32'hED);
    check("pin_isbox_00", 32'(isbox_ref[8'h00]), 32'h52);
    check("pin_isbox_63", 32'(isbox_ref[8'h63]), 32'h00);
    check("pin_isbox_7c", 32'(isbox_ref[8'h7C]), 32'h01);
    set_rom(1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle", 32'(bus.ap_idle), 32'd1);
    check("reset_done", 32'(bus.ap_done), 32'd0);

    // identity ROM, ramp data: pure InvShiftRows
    normal_op("t1", 0, 0);
    check("t1_e0", mem[0], 32'h00);
    check("t1_e1", mem[1], 32'h13);
    check("t1_e2", mem[2], 32'h22);
    check("t1_e3", mem[3], 32'h31);
    check("t1_e5", mem[5], 32'h10);

    // real inverse S-box
    set_rom(1'b1);
    normal_op("t2", 1, 0);
    check("t2_e7", mem[7], 32'h00);
    normal_op("t3", 2, 0);
    check("t3_e0", mem[0], 32'h01);

    // start toggling while busy
    for (int j = 0; j < 4; j++) normal_op($sformatf("t6_%0d", j), 3, 1);

    // start held high: two back-to-back applications
    load_mem(3);
    snap_model();
    apply_model(16);
    apply_model(16);
    push_expected();
    run_ops(2, 2, 0);
    check("t5_done0", 32'(done_cyc[0]), 32'd18);
    check("t5_done1", 32'(done_cyc[1]), 32'd37);
    check_mem("t5");

    // reset during SUB at cycle 12: only the cycle-11 pair was committed
    load_mem(3);
    snap_model();
    apply_model(2);
    push_expected();
    run_ops(1, 0, 12);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t4_idle", 32'(bus.ap_idle), 32'd1);
    check("t4_done", 32'(bus.ap_done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_mem("t4");

    // recovery after abort
    normal_op("t7", 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
